// File: rtl/brick_collide_scan.sv
// Scans brick memory for ball/brick overlap, decrements health of hit bricks,
// requests redraws and raises sticky bounce flags. Define BRICK_MULTI_HIT_EN to
// keep scanning after a hit instead of ending the scan at the first one.
module brick_collide_scan #(
  parameter int unsigned NUM_BRICKS = 60,
  parameter int unsigned BRICK_W    = 8,
  parameter int unsigned BRICK_H    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] size,
  output logic [6:0] mem_addr,
  input  logic [9:0] mem_x,
  input  logic [9:0] mem_y,
  input  logic [1:0] mem_health,
  output logic       mem_wren,
  output logic [1:0] mem_health_out,
  output logic       draw_go,
  input  logic       draw_busy,
  output logic [9:0] draw_x,
  output logic [9:0] draw_y,
  output logic [1:0] draw_health,
  output logic       flip_x,
  output logic       flip_y,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 11;
  localparam int unsigned AW = 7;
  localparam int unsigned HW = 2;

  typedef enum logic [3:0] {
    IDLE, ADDR, READ, CHECK, WRITE, DRAW_REQ, DRAW_WAIT, NEXT, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] index;
  logic [CW-1:0] hit_x;
  logic [CW-1:0] hit_y;
  logic [HW-1:0] hit_health;

  // Overlap test in 11 bits so brick/ball extents past 1023 do not wrap.
  logic [SW-1:0] bx_c, by_c, bs_c, mx_c, my_c;
  logic          hit_c, vert_c;
  assign bx_c   = SW'(ball_x);
  assign by_c   = SW'(ball_y);
  assign bs_c   = SW'(size);
  assign mx_c   = SW'(mem_x);
  assign my_c   = SW'(mem_y);
  assign hit_c  = (mem_health != '0) &&
                  (bx_c < mx_c + SW'(BRICK_W)) && (mx_c < bx_c + bs_c) &&
                  (by_c < my_c + SW'(BRICK_H)) && (my_c < by_c + bs_c);
  assign vert_c = (by_c < my_c) || (by_c + bs_c > my_c + SW'(BRICK_H));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      index          <= '0;
      hit_x          <= '0;
      hit_y          <= '0;
      hit_health     <= '0;
      mem_addr       <= '0;
      mem_wren       <= 1'b0;
      mem_health_out <= '0;
      draw_go        <= 1'b0;
      draw_x         <= '0;
      draw_y         <= '0;
      draw_health    <= '0;
      flip_x         <= 1'b0;
      flip_y         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      draw_go  <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state  <= ADDR;
            index  <= '0;
            flip_x <= 1'b0;
            flip_y <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ADDR: begin
          mem_addr <= index;
          state    <= READ;
        end
        READ: state <= CHECK;
        CHECK: begin
          if (hit_c) begin
            hit_x          <= mem_x;
            hit_y          <= mem_y;
            hit_health     <= HW'(mem_health - 2'd1);
            mem_wren       <= 1'b1;
            mem_health_out <= HW'(mem_health - 2'd1);
            if (vert_c) flip_y <= 1'b1;
            else        flip_x <= 1'b1;
            state <= WRITE;
          end else begin
            state <= NEXT;
          end
        end
        WRITE: state <= DRAW_REQ;
        DRAW_REQ: begin
          if (!draw_busy) begin
            draw_go     <= 1'b1;
            draw_x      <= hit_x;
            draw_y      <= hit_y;
            draw_health <= hit_health;
            state       <= DRAW_WAIT;
          end
        end
        DRAW_WAIT: begin
          // draw_go is still high on the first cycle here; the drawer sees busy after it.
          if (!draw_go && !draw_busy) begin
`ifdef BRICK_MULTI_HIT_EN
            state <= NEXT;
`else
            state <= DONE;
`endif
          end
        end
        NEXT: begin
          if (index == AW'(NUM_BRICKS - 1)) begin
            state <= DONE;
          end else begin
            index <= AW'(index + 1'b1);
            state <= ADDR;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_collide_scan.sv
// Self-checking bench for brick_collide_scan: RAM and drawer models, directed
// scenarios and randomized scans compared against a per-brick reference model.
module tb_brick_collide_scan;

  localparam int unsigned N  = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned BH = 4;
`ifdef BRICK_MULTI_HIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, go, draw_busy, mem_wren, draw_go, flip_x, flip_y, busy, done;
  logic [9:0] ball_x, ball_y, size, mem_x, mem_y, draw_x, draw_y;
  logic [6:0] mem_addr;
  logic [1:0] mem_health, mem_health_out, draw_health;

  brick_collide_scan #(.NUM_BRICKS(N), .BRICK_W(BW), .BRICK_H(BH)) dut (
    .clk(clk), .resetn(resetn), .go(go), .ball_x(ball_x), .ball_y(ball_y),
    .size(size), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .mem_health(mem_health), .mem_wren(mem_wren), .mem_health_out(mem_health_out),
    .draw_go(draw_go), .draw_busy(draw_busy), .draw_x(draw_x), .draw_y(draw_y),
    .draw_health(draw_health), .flip_x(flip_x), .flip_y(flip_y), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Brick RAM contents (written only by the main process) with one-cycle read.
  logic [9:0] bx [128];
  logic [9:0] by [128];
  logic [1:0] bh [128];
  always @(posedge clk) begin
    mem_x      <= bx[mem_addr];
    mem_y      <= by[mem_addr];
    mem_health <= bh[mem_addr];
  end

  // Event log of writes, draws and done pulses.
  logic [8:0]  wr_q [$];
  logic [21:0] dr_q [$];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (mem_wren) wr_q.push_back({mem_addr, mem_health_out});
    if (draw_go)  dr_q.push_back({draw_x, draw_y, draw_health});
    if (done)     done_cnt++;
  end

  // Drawer: random busy time after each draw_go, or held busy on request.
  logic force_busy = 1'b0;
  int   busy_left  = 0;
  initial begin
    draw_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (draw_go) busy_left = $urandom_range(0, 4);
      else if (busy_left > 0) busy_left--;
      draw_busy = force_busy || (busy_left > 0);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model results.
  logic [8:0]  exp_w [$];
  logic [21:0] exp_d [$];
  logic        exp_fx, exp_fy;

  task automatic model(input int x, input int y, input int s);
    int mx, my;
    logic [1:0] nh;
    exp_w.delete(); exp_d.delete();
    exp_fx = 1'b0; exp_fy = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      mx = int'(bx[i]); my = int'(by[i]);
      if (bh[i] != 0 && x < mx + BW && mx < x + s && y < my + BH && my < y + s) begin
        nh = bh[i] - 2'd1;
        exp_w.push_back({7'(i), nh});
        exp_d.push_back({bx[i], by[i], nh});
        if (y < my || y + s > my + BH) exp_fy = 1'b1;
        else                           exp_fx = 1'b1;
        if (!MULTI) break;
      end
    end
  endtask

  task automatic layout_far();
    for (int i = 0; i < 128; i++) begin
      bx[i] = 10'(200 + (i % 32) * 8);
      by[i] = 10'((i % 8) * 4);
      bh[i] = 2'd3;
    end
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    ball_x = 10'(x); ball_y = 10'(y); size = 10'(s);
  endtask

  // Pulse go, optionally pulse it again mid-scan, and count cycles to done.
  task automatic do_scan(input int extra_go, output int cyc);
    @(negedge clk);
    go  = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      go = (extra_go > 0 && cyc == extra_go);
      if (done === 1'b1) break;
    end
    go = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Compare logged writes/draws/flips against the model; mirror writes into RAM.
  task automatic check_scan(input string tag, input int w0, input int d0);
    chk({tag, "_nwr"}, 32'(wr_q.size() - w0), 32'(exp_w.size()));
    chk({tag, "_ndraw"}, 32'(dr_q.size() - d0), 32'(exp_d.size()));
    for (int k = 0; k < exp_w.size() && w0 + k < wr_q.size(); k++)
      chk($sformatf("%s_wr%0d", tag, k), 32'(wr_q[w0 + k]), 32'(exp_w[k]));
    for (int k = 0; k < exp_d.size() && d0 + k < dr_q.size(); k++)
      chk($sformatf("%s_draw%0d", tag, k), 32'(dr_q[d0 + k]), 32'(exp_d[k]));
    chk({tag, "_flip_x"}, 32'(flip_x), 32'(exp_fx));
    chk({tag, "_flip_y"}, 32'(flip_y), 32'(exp_fy));
    for (int k = w0; k < wr_q.size(); k++) bh[wr_q[k][8:2]] = wr_q[k][1:0];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wren"}, 32'(mem_wren), 0);
    chk({tag, "_hout"}, 32'(mem_health_out), 0);
    chk({tag, "_draw_go"}, 32'(draw_go), 0);
    chk({tag, "_draw"}, 32'({draw_x, draw_y, draw_health}), 0);
    chk({tag, "_flips"}, 32'({flip_x, flip_y}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int cyc, w0, d0, dc0;
    resetn = 1'b0; go = 1'b0;
    set_ball(0, 100, 2);
    layout_far();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) resetn = 1'b1;

    // No hit anywhere: exact scan length, no writes, no flips.
    for (int i = 0; i < 128; i++) by[i] = 10'(i % 36);
    set_ball(0, 100, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(0, 100, 2);
    do_scan(0, cyc);
    chk("nohit_cycles", 32'(cyc), 32'(4 * N + 2));
    chk("nohit_busy_after", 32'(busy), 0);
    check_scan("nohit", w0, d0);

    // Side hit on brick 5.
    layout_far();
    bx[5] = 10'd40; by[5] = 10'd20; bh[5] = 2'd2;
    set_ball(47, 21, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(47, 21, 2);
    do_scan(0, cyc);
    check_scan("side", w0, d0);
    chk("side_wr_lit", 32'(wr_q[w0]), 32'({7'd5, 2'd1}));
    chk("side_draw_lit", 32'(dr_q[d0]), 32'({10'd40, 10'd20, 2'd1}));
    chk("side_flips_lit", 32'({flip_x, flip_y}), 32'(2'b10));

    // Top hit on brick 0 kills it.
    layout_far();
    bx[0] = 10'd40; by[0] = 10'd20; bh[0] = 2'd1;
    set_ball(42, 19, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(42, 19, 2);
    do_scan(0, cyc);
    check_scan("top", w0, d0);
    chk("top_draw_lit", 32'(dr_q[d0]), 32'({10'd40, 10'd20, 2'd0}));
    chk("top_flip_y_lit", 32'(flip_y), 1);

    // Dead brick overlapping the ball is ignored (brick 0 now has health 0).
    w0 = wr_q.size(); d0 = dr_q.size();
    model(42, 19, 2);
    do_scan(0, cyc);
    check_scan("dead", w0, d0);
    chk("dead_cycles", 32'(cyc), 32'(4 * N + 2));

    // Right edge near 1023: sums must not wrap.
    layout_far();
    bx[0] = 10'd1020; by[0] = 10'd20; bh[0] = 2'd3;
    bx[1] = 10'd40;   by[1] = 10'd20; bh[1] = 2'd3;
    set_ball(1023, 20, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(1023, 20, 2);
    do_scan(0, cyc);
    check_scan("wrap", w0, d0);

    // Ball touching brick edge exactly is not a hit.
    set_ball(48, 20, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(48, 20, 2);
    do_scan(0, cyc);
    check_scan("touch", w0, d0);

    // Drawer busy holds off draw_go, which then fires once.
    layout_far();
    bx[0] = 10'd40; by[0] = 10'd20; bh[0] = 2'd2;
    set_ball(47, 21, 2);
    model(47, 21, 2);
    w0 = wr_q.size(); d0 = dr_q.size();
    @(negedge clk) force_busy = 1'b1;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("hold_draw_go%0d", k), 32'(draw_go), 0);
    end
    chk("hold_busy", 32'(busy), 1);
    chk("hold_ndraw", 32'(dr_q.size() - d0), 0);
    force_busy = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    chk("hold_done", 32'(done), 1);
    check_scan("hold", w0, d0);

    // Reset in the middle of a hit abandons the pending draw.
    layout_far();
    bx[0] = 10'd40; by[0] = 10'd20; bh[0] = 2'd3;
    set_ball(47, 21, 2);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pending_wren", 32'(mem_wren), 1);
    d0 = dr_q.size(); dc0 = done_cnt;
    resetn = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    @(negedge clk) resetn = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_draw", 32'(dr_q.size() - d0), 0);
    chk("midrst_no_done", 32'(done_cnt - dc0), 0);
    chk("midrst_idle", 32'(busy), 0);
    bh[0] = 2'd2;

    // go during a scan is ignored.
    for (int i = 0; i < 128; i++) by[i] = 10'(i % 36);
    set_ball(0, 100, 2);
    dc0 = done_cnt;
    do_scan(10, cyc);
    chk("rego_cycles", 32'(cyc), 32'(4 * N + 2));
    repeat (4) @(negedge clk);
    chk("rego_one_done", 32'(done_cnt - dc0), 1);
    chk("rego_idle", 32'(busy), 0);

    // Two overlapping live bricks.
    layout_far();
    bx[2] = 10'd40; by[2] = 10'd20; bh[2] = 2'd2;
    bx[7] = 10'd44; by[7] = 10'd20; bh[7] = 2'd3;
    set_ball(43, 21, 4);
    w0 = wr_q.size(); d0 = dr_q.size();
    model(43, 21, 4);
    do_scan(0, cyc);
    check_scan("multi", w0, d0);
    chk("multi_nwr_lit", 32'(wr_q.size() - w0), MULTI ? 32'd2 : 32'd1);

    // Randomized scans in a crowded field.
    for (int t = 0; t < 25; t++) begin
      int x, y, s;
      for (int i = 0; i < int'(N); i++) begin
        bx[i] = 10'($urandom_range(0, 60));
        by[i] = 10'($urandom_range(0, 30));
        bh[i] = 2'($urandom_range(0, 3));
      end
      x = $urandom_range(0, 64); y = $urandom_range(0, 34); s = $urandom_range(1, 12);
      set_ball(x, y, s);
      w0 = wr_q.size(); d0 = dr_q.size();
      model(x, y, s);
      do_scan(0, cyc);
      check_scan($sformatf("rnd%0d", t), w0, d0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brick_collide_scan.md
BRICK_COLLIDE_SCAN -- requirements
Module: brick_collide_scan

Interface
REQ-001 SHALL have parameter NUM_BRICKS, default 60, number of brick memory entries scanned (addresses 0..NUM_BRICKS-1).
REQ-002 SHALL have parameter BRICK_W, default 8, brick width in pixels.
REQ-003 SHALL have parameter BRICK_H, default 4, brick height in pixels.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port go  input  1  one-cycle scan start pulse.
REQ-007 SHALL have ports ball_x, ball_y  input  10 each  ball top-left pixel.
REQ-008 SHALL have port size  input  10  ball edge length in pixels.
REQ-009 SHALL have port mem_addr  output  7  brick memory read/write address.
REQ-010 SHALL have ports mem_x, mem_y  input  10 each, and mem_health  input  2, giving brick origin and health at mem_addr.
REQ-011 SHALL have ports mem_wren  output  1, and mem_health_out  output  2, the brick health write-back.
REQ-012 SHALL have ports draw_go  output  1  one-cycle brick redraw request, and draw_busy  input  1  brick drawer busy.
REQ-013 SHALL have ports draw_x, draw_y  output  10 each, and draw_health  output  2, the redraw target.
REQ-014 SHALL have ports flip_x, flip_y  output  1 each  sticky bounce flags; busy  output  1; done  output  1  one-cycle end-of-scan pulse.

Function
REQ-015 SHALL implement states IDLE, ADDR, READ, CHECK, WRITE, DRAW_REQ, DRAW_WAIT, NEXT, DONE.
REQ-016 IDLE: go=1 -> ADDR, with index cleared to 0 and flip_x/flip_y cleared; go is ignored in every other state.
REQ-017 ADDR drives mem_addr=index; READ waits one cycle for the memory's one-cycle read latency; CHECK samples mem_x, mem_y, mem_health.
REQ-018 Hit condition: mem_health!=0 AND ball_x < mem_x+BRICK_W AND mem_x < ball_x+size AND ball_y < mem_y+BRICK_H AND mem_y < ball_y+size, using 11-bit sums with no wrap.
REQ-019 No hit -> NEXT; hit -> WRITE.
REQ-020 WRITE asserts mem_wren for exactly one cycle with mem_health_out=mem_health-1 at mem_addr=index.
REQ-021 On a hit, flip_y SHALL be set if ball_y < mem_y or ball_y+size > mem_y+BRICK_H; otherwise flip_x SHALL be set.
REQ-022 DRAW_REQ: wait while draw_busy=1; when draw_busy=0, pulse draw_go for 1 cycle with draw_x=mem_x, draw_y=mem_y, draw_health=new health (0 means erase) -> DRAW_WAIT.
REQ-023 DRAW_WAIT: stay while draw_busy=1 or in the first cycle after draw_go -> NEXT.
REQ-024 NEXT: index==NUM_BRICKS-1 -> DONE, else index+1 -> ADDR.
REQ-025 DONE pulses done for one cycle -> IDLE; flip_x/flip_y hold until the next accepted go.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 mem_wren SHALL be 0 in all states except WRITE; draw outputs hold their last values outside DRAW_REQ.
REQ-028 A full scan with no hits SHALL take exactly 4*NUM_BRICKS+2 cycles from go to done.

Reset
REQ-029 resetn=0 SHALL force IDLE, index=0, mem_addr=0, mem_wren=0, mem_health_out=0, draw_go=0, draw_x=draw_y=0, draw_health=0, flip_x=flip_y=0, busy=0, done=0, on the next clk edge, including mid-scan; a pending write or draw_go is abandoned.

Configuration
REQ-030 With macro BRICK_MULTI_HIT_EN defined, the scan SHALL continue through all bricks after a hit, so one scan can damage several bricks.
REQ-031 Without BRICK_MULTI_HIT_EN, the first hit SHALL go from DRAW_WAIT directly to DONE, so at most one brick is damaged per scan.

Verification
REQ-032 No hit: ball (0,100), size 2, all bricks at y<40 -> done exactly 4*NUM_BRICKS+2 cycles after go; mem_wren, flip_x and flip_y never asserted.
REQ-033 Side hit: brick 5 at (40,20) health 2, ball (47,21) size 2 -> one mem_wren at addr 5 with health_out 1; draw_go with (40,20,1); flip_x=1, flip_y=0.
REQ-034 Top hit: brick 0 at (40,20) health 1, ball (42,19) size 2 -> health_out 0, draw_health 0, flip_y=1.
REQ-035 Dead brick: brick overlaps ball but health 0 -> no write, no draw_go.
REQ-036 Handshake and reset: hold draw_busy=1 for 10 cycles during DRAW_REQ -> draw_go waits, then fires once; resetn=0 mid-scan -> all outputs zero the next cycle; go during busy is ignored.
REQ-037 Multi-hit: two overlapping live bricks -> two writes with BRICK_MULTI_HIT_EN defined, one write without it.
